// File: rtl/mux_rr_scheduler_if.sv
// Requester/mux/output channel bundle for mux_rr_scheduler.
// The scheduler takes the master side; the requesters and the downstream sink take the slave side.
interface mux_rr_scheduler_if #(
  parameter int WIDTH = 8
);
  logic [3:0]       req;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic             out_ready;
  logic [3:0]       gnt;
  logic             S2;
  logic             S1;
  logic [WIDTH-1:0] y;
  logic             y_valid;
  logic             busy;

  modport master (
    input  req, a, b, c, d, out_ready,
    output gnt, S2, S1, y, y_valid, busy
  );

  modport slave (
    output req, a, b, c, d, out_ready,
    input  gnt, S2, S1, y, y_valid, busy
  );
endinterface

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler for a shared 4:1 mux: grants one requester at a time for at most
// MAX_HOLD beats, drives {S2,S1} to the granted index and registers the selected word onto y.
module mux_rr_scheduler #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input logic                  clk,
  input logic                  rst,
  mux_rr_scheduler_if.master   io_bus
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t           r_state, w_state_next;
  logic [1:0]       r_ptr, w_ptr_next;
  logic [3:0]       r_cnt, w_cnt_next;
  logic [1:0]       r_sel, w_sel_next;
  logic [3:0]       r_gnt, w_gnt_next;
  logic [WIDTH-1:0] r_y, w_y_next;
  logic             r_y_valid, w_y_valid_next;

  logic [WIDTH-1:0] w_data [4];
  logic [3:0]       w_rot_req;
  logic [1:0]       w_off;
  logic [1:0]       w_scan_idx;
  logic             w_hold_req;
  logic             w_stall;
  logic             w_load;
  logic [3:0]       w_cnt_inc;

  assign w_data[0] = io_bus.a;
  assign w_data[1] = io_bus.b;
  assign w_data[2] = io_bus.c;
  assign w_data[3] = io_bus.d;

  // Requests rotated so that bit 0 is the source the pointer currently favours.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rot
      logic [1:0] w_idx;
      assign w_idx         = r_ptr + 2'(gi);
      assign w_rot_req[gi] = io_bus.req[w_idx];
    end
  endgenerate

  always_comb begin
    w_off = 2'd3;
    if (w_rot_req[0])      w_off = 2'd0;
    else if (w_rot_req[1]) w_off = 2'd1;
    else if (w_rot_req[2]) w_off = 2'd2;
  end

  assign w_scan_idx = r_ptr + w_off;
  assign w_hold_req = io_bus.req[r_sel];
  assign w_stall    = r_y_valid & ~io_bus.out_ready;
  assign w_cnt_inc  = r_cnt + 4'd1;

  always_comb begin
    w_state_next   = r_state;
    w_ptr_next     = r_ptr;
    w_cnt_next     = r_cnt;
    w_sel_next     = r_sel;
    w_gnt_next     = r_gnt;
    w_y_next       = r_y;
    w_y_valid_next = r_y_valid;
    w_load         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (|io_bus.req) begin
          w_gnt_next   = 4'b0001 << w_scan_idx;
          w_sel_next   = w_scan_idx;
          w_cnt_next   = 4'd0;
          w_state_next = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!w_hold_req) begin
          w_gnt_next   = 4'b0000;
          w_state_next = ST_IDLE;
          w_ptr_next   = r_sel + 2'd1;
          w_cnt_next   = 4'd0;
        end else if (!w_stall) begin
          w_load     = 1'b1;
          w_cnt_next = w_cnt_inc;
          // The last permitted beat and the release share one edge.
          if (w_cnt_inc == 4'(MAX_HOLD)) begin
            w_gnt_next   = 4'b0000;
            w_state_next = ST_IDLE;
            w_ptr_next   = r_sel + 2'd1;
            w_cnt_next   = 4'd0;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_gnt_next   = 4'b0000;
      end
    endcase

    if (w_load) begin
      w_y_next       = w_data[r_sel];
      w_y_valid_next = 1'b1;
    end else if (io_bus.out_ready) begin
      w_y_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ptr     <= 2'd0;
      r_cnt     <= 4'd0;
      r_sel     <= 2'd0;
      r_gnt     <= 4'b0000;
      r_y       <= '0;
      r_y_valid <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_ptr     <= w_ptr_next;
      r_cnt     <= w_cnt_next;
      r_sel     <= w_sel_next;
      r_gnt     <= w_gnt_next;
      r_y       <= w_y_next;
      r_y_valid <= w_y_valid_next;
    end
  end

  assign io_bus.gnt     = r_gnt;
  assign io_bus.S2      = r_sel[1];
  assign io_bus.S1      = r_sel[0];
  assign io_bus.y       = r_y;
  assign io_bus.y_valid = r_y_valid;
  assign io_bus.busy    = (r_state == ST_GRANT);

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Self-checking bench for mux_rr_scheduler: directed vector table, hand-written corner
// sequences, and a randomized run against a queue-based reference model.
module tb_mux_rr_scheduler;

  localparam int W  = 8;
  localparam int MH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req = 4'b0000;
  logic [W-1:0] a = '0, b = '0, c = '0, d = '0;
  logic         out_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_rr_scheduler_if #(.WIDTH(W)) if4 ();
  mux_rr_scheduler_if #(.WIDTH(W)) if2 ();

  assign if4.req = req;  assign if4.a = a;  assign if4.b = b;
  assign if4.c = c;      assign if4.d = d;  assign if4.out_ready = out_ready;
  assign if2.req = req;  assign if2.a = a;  assign if2.b = b;
  assign if2.c = c;      assign if2.d = d;  assign if2.out_ready = out_ready;

  mux_rr_scheduler #(.WIDTH(W), .MAX_HOLD(MH)) dut4 (.clk(clk), .rst(rst), .io_bus(if4.master));
  mux_rr_scheduler #(.WIDTH(W), .MAX_HOLD(2))  dut2 (.clk(clk), .rst(rst), .io_bus(if2.master));

  typedef struct {
    logic [3:0] req;
    logic [7:0] a;
    logic       rdy;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       yv;
    logic [7:0] y;
    logic       busy;
  } vec_t;

  vec_t tbl[7];

  // Reference model: owner of the mux (-1 when nobody), beats taken, pending output word.
  int         m_owner, m_last, m_ptr, m_beats;
  bit         m_pend;
  logic [7:0] m_y;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] snap4();
    return {if4.gnt, if4.S2, if4.S1, if4.busy, if4.y_valid, if4.y};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_owner = -1; m_last = 0; m_ptr = 0; m_beats = 0; m_pend = 0; m_y = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 4'b0000; out_ready = 1'b1;
    a = '0; b = '0; c = '0; d = '0;
    repeat (2) tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic model_release();
    m_ptr   = (m_owner + 1) % 4;
    m_owner = -1;
    m_beats = 0;
  endtask

  task automatic model_step();
    logic [7:0] words[4];
    bit accept, load, found;
    words = '{a, b, c, d};
    accept = m_pend && out_ready;
    load = 0;
    if (m_owner < 0) begin
      found = 0;
      for (int k = 0; k < 4; k++) begin
        int i;
        i = (m_ptr + k) % 4;
        if (!found && req[i]) begin
          found = 1; m_owner = i; m_last = i; m_beats = 0;
          $display("rand: grant source %0d", i);
        end
      end
    end else if (!req[m_owner]) begin
      model_release();
    end else if (!(m_pend && !out_ready)) begin
      load = 1;
      m_y = words[m_owner];
      m_beats++;
      if (m_beats == MH) model_release();
    end
    if (load) m_pend = 1;
    else if (accept) m_pend = 0;
  endtask

  function automatic logic [15:0] model_snap();
    logic [3:0] g;
    logic [1:0] s;
    g = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    s = 2'(m_last);
    return {g, s, (m_owner >= 0), m_pend, m_y};
  endfunction

  initial begin
    int acc;

    tbl[0] = '{4'b0001, 8'h11, 1'b1, 4'b0001, 2'd0, 1'b0, 8'h00, 1'b1};
    tbl[1] = '{4'b0001, 8'h11, 1'b1, 4'b0001, 2'd0, 1'b1, 8'h11, 1'b1};
    tbl[2] = '{4'b0001, 8'h11, 1'b1, 4'b0001, 2'd0, 1'b1, 8'h11, 1'b1};
    tbl[3] = '{4'b0001, 8'h11, 1'b1, 4'b0001, 2'd0, 1'b1, 8'h11, 1'b1};
    tbl[4] = '{4'b0001, 8'h11, 1'b1, 4'b0000, 2'd0, 1'b1, 8'h11, 1'b0};
    tbl[5] = '{4'b0001, 8'h11, 1'b1, 4'b0001, 2'd0, 1'b0, 8'h11, 1'b1};
    tbl[6] = '{4'b0001, 8'h11, 1'b1, 4'b0001, 2'd0, 1'b1, 8'h11, 1'b1};

    // Reset state
    do_reset();
    check("reset_state", 32'(snap4()), 32'h0);
    $display("reset: snapshot %h", snap4());

    // Single requester, full rate
    for (int i = 0; i < 7; i++) begin
      req = tbl[i].req; a = tbl[i].a; out_ready = tbl[i].rdy;
      tick();
      check($sformatf("single_edge%0d", i + 1), 32'(snap4()),
            32'({tbl[i].gnt, tbl[i].sel, tbl[i].busy, tbl[i].yv, tbl[i].y}));
      $display("single: edge %0d gnt=%b sel=%0d yv=%b y=%h", i + 1, if4.gnt, {if4.S2, if4.S1},
               if4.y_valid, if4.y);
    end

    // Round robin with wrap, MAX_HOLD=2
    do_reset();
    req = 4'b1111; a = 8'hA0; b = 8'hA1; c = 8'hA2; d = 8'hA3;
    for (int n = 1; n <= 13; n++) begin
      int idx, ph;
      logic [3:0] eg;
      tick();
      idx = ((n - 1) / 3) % 4;
      ph  = (n - 1) % 3;
      eg  = (ph < 2) ? 4'(1 << idx) : 4'b0000;
      check($sformatf("rr_edge%0d", n), 32'({if2.gnt, if2.S2, if2.S1, if2.y_valid}),
            32'({eg, 2'(idx), (ph != 0)}));
      if (ph != 0) check($sformatf("rr_y_edge%0d", n), 32'(if2.y), 32'(8'hA0 + idx));
      $display("rr: edge %0d gnt=%b sel=%0d", n, if2.gnt, {if2.S2, if2.S1});
    end

    // Backpressure
    do_reset();
    req = 4'b0100; c = 8'hCC;
    tick();
    check("bp_grant", 32'(if4.gnt), 32'h4);
    tick();
    check("bp_first_beat", 32'({if4.y_valid, if4.y}), 32'({1'b1, 8'hCC}));
    out_ready = 1'b0; c = 8'hCD;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("bp_stall%0d", i), 32'({if4.gnt, if4.y_valid, if4.y}),
            32'({4'b0100, 1'b1, 8'hCC}));
    end
    out_ready = 1'b1;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      if (if4.y_valid) acc++;
      tick();
      if (i == 0) check("bp_resume_y", 32'(if4.y), 32'hCD);
      if (i == 2) begin
        check("bp_release", 32'(if4.gnt), 32'h0);
        req = 4'b0000;
      end
    end
    check("bp_beats", 32'(acc), 32'd4);
    $display("backpressure: %0d beats delivered", acc);

    // Early release
    do_reset();
    req = 4'b0010; b = 8'hBB;
    tick();
    check("er_grant", 32'(if4.gnt), 32'h2);
    acc = 0;
    for (int i = 0; i < 3; i++) begin
      if (if4.y_valid) acc++;
      tick();
      if (i == 1) req = 4'b0000;
    end
    check("er_release", 32'({if4.gnt, if4.y_valid}), 32'h0);
    check("er_beats", 32'(acc), 32'd2);
    req = 4'b0011;
    tick();
    check("er_regrant_src0", 32'({if4.gnt, if4.S2, if4.S1}), 32'({4'b0001, 2'd0}));
    $display("early release: %0d beats, next grant %b", acc, if4.gnt);

    // Reset mid-burst
    do_reset();
    req = 4'b1000; d = 8'hDD;
    tick();
    check("rst_grant3", 32'({if4.gnt, if4.S2, if4.S1}), 32'({4'b1000, 2'd3}));
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    check("rst_mid_burst", 32'(snap4()), 32'h0);
    req = 4'b1001;
    tick();
    rst = 1'b0;
    tick();
    check("rst_then_src0", 32'({if4.gnt, if4.S2, if4.S1}), 32'({4'b0001, 2'd0}));
    $display("reset mid-burst: next grant %b", if4.gnt);

    // Skip idle sources
    do_reset();
    req = 4'b0001;
    tick();
    req = 4'b0000;
    tick();
    check("skip_release", 32'(if4.gnt), 32'h0);
    req = 4'b1000;
    tick();
    check("skip_grant3", 32'({if4.gnt, if4.S2, if4.S1}), 32'({4'b1000, 2'd3}));
    $display("skip idle: grant %b sel=%0d", if4.gnt, {if4.S2, if4.S1});

    // Randomized run against the reference model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom % 6 == 0) req = 4'($urandom);
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
      out_ready = ($urandom % 4) != 0;
      model_step();
      tick();
      check($sformatf("rand_cycle%0d", n), 32'(snap4()), 32'(model_snap()));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
